weight_bank: RTL
================

// Module: weight_bank
// PURPOSE
//  Parametrised synaptic weight store replacing the free-running random weight generator.
//  Holds NUM_SYNAPSES unsigned weights and fills them with a seedable, deterministic LFSR sequence.
//  Supports host writes, saturating learning updates and registered single-address reads.
//  All weights are also presented on a flattened parallel bus for the neuron array.
// PARAMETERS
//  NUM_SYNAPSES  100      number of weights; must be >= 2
//  WIDTH_P       8        weight width in bits; must be 2..16
//  LFSR_SEED     16'hACE1 fallback seed, used when seed_i == 0
//  ADDR_W        (local)  $clog2(NUM_SYNAPSES)
// PORTS
//  clk_i         in   1            clock; all state updates on the rising edge
//  rst_i         in   1            synchronous, active-high reset
//  fill_start_i  in   1            request a pseudo-random fill of all weights
//  seed_i        in   16           LFSR seed, captured on an accepted fill_start_i
//  busy_o        out  1            high while in the FILL state
//  fill_done_o   out  1            one-cycle pulse when the fill completes
//  wr_valid_i    in   1            host write request
//  wr_ready_o    out  1            write accepted when wr_valid_i && wr_ready_o
//  wr_addr_i     in   ADDR_W       write address
//  wr_data_i     in   WIDTH_P      write data
//  upd_valid_i   in   1            learning update request
//  upd_ready_o   out  1            update accepted when upd_valid_i && upd_ready_o
//  upd_addr_i    in   ADDR_W       update address
//  upd_delta_i   in   WIDTH_P      signed two's-complement delta
//  rd_addr_i     in   ADDR_W       read address, sampled every cycle
//  rd_data_o     out  WIDTH_P      registered read data, 1-cycle latency
//  weights_o     out  NUM_SYNAPSES*WIDTH_P  all weights; weight i at [i*WIDTH_P +: WIDTH_P]
// BEHAVIOUR
//  Reset: all weights = 0, state = IDLE, lfsr = LFSR_SEED, fill address = 0, rd_data_o = 0, fill_done_o = 0.
//   Reset applies mid-fill with no residue: the fill is abandoned and all outputs match the reset values.
//  FSM states: IDLE -> FILL on fill_start_i; FILL -> READY after the last address; READY -> FILL on fill_start_i.
//   fill_start_i is ignored while in FILL.
//  Fill start: lfsr <= (seed_i == 0) ? LFSR_SEED : seed_i; fill address <= 0.
//  LFSR: 16-bit Galois, right shift: nxt = (l >> 1) ^ (l[0] ? 16'hB400 : 0).
//  FILL, each cycle: lfsr <= nxt; weight[addr] <= nxt[WIDTH_P-1:0]; addr++.
//   A fill takes exactly NUM_SYNAPSES cycles.
//   In the cycle that writes addr NUM_SYNAPSES-1, the next state is READY and fill_done_o pulses in the following cycle.
//  busy_o = (state == FILL). wr_ready_o = upd_ready_o = 0 during FILL, so requests stall.
//  Outside FILL: wr_ready_o = 1; upd_ready_o = !wr_valid_i (a write wins any same-cycle update).
//  Write: weight[wr_addr_i] <= wr_data_i. Update: weight = clamp(weight + sext(delta), 0, 2^WIDTH_P-1).
//   Compute the update in WIDTH_P+2 signed bits.
//   Example (WIDTH_P = 8): 250 + 10 -> 255; 3 + (-5) -> 0.
//  An out-of-range address (>= NUM_SYNAPSES) on a write or update is still handshaken, but no weight changes.
//  Read: rd_data_o <= weight[rd_addr_i], or 0 if the address is out of range.
//   Read-before-write: a same-cycle write to the read address returns the old value.
//  weights_o is a direct view of the registers; a change is visible one cycle after the accepting edge.
//  The update path reads the current weight; writes and updates never collide, since at most one is accepted per cycle.
// TESTING
//  Reset, then idle 5 cycles -> every weight = 0; busy_o = 0; rd_data_o = 0; wr_ready_o = 1.
//  W=8, N=100, seed_i = 16'hACE1, fill:
//   -> weight[0] = 8'h70, weight[1] = 8'h38;
//   -> busy_o high for exactly 100 cycles, then one fill_done_o pulse;
//   -> a repeat fill gives an identical image; seed_i = 0 gives the same image as 16'hACE1.
//  Write addr 5 = 8'hAA, then read addr 5 -> rd_data_o = 8'hAA one cycle later.
//   Write and read addr 5 = 8'h55 in the same cycle -> the read returns 8'hAA.
//  Updates: weight 250 with delta +10 -> 255; weight 3 with delta 8'hFB -> 0; weight 100 with delta -1 -> 99.
//  Write and update in the same cycle -> only the write lands; upd_ready_o = 0 that cycle.
//   Write or update during FILL -> ready stays low and the request completes after READY.
//  Assert rst_i at fill cycle 40 -> all weights = 0, state IDLE.
//   Write to addr 120 -> handshaken, but weights_o is unchanged.

Source files
------------

// File: rtl/weight_bank.sv
// ============================================================================
// weight_bank: synaptic weight store with LFSR fill, host writes, saturating
// learning updates, registered reads and a flattened parallel weight bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module weight_bank #(
  parameter int          NUM_SYNAPSES = 100,
  parameter int          WIDTH_P      = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int         ADDR_W       = $clog2(NUM_SYNAPSES)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            fill_start_i,
  input  logic [15:0]                     seed_i,
  output logic                            busy_o,
  output logic                            fill_done_o,
  input  logic                            wr_valid_i,
  output logic                            wr_ready_o,
  input  logic [ADDR_W-1:0]               wr_addr_i,
  input  logic [WIDTH_P-1:0]              wr_data_i,
  input  logic                            upd_valid_i,
  output logic                            upd_ready_o,
  input  logic [ADDR_W-1:0]               upd_addr_i,
  input  logic [WIDTH_P-1:0]              upd_delta_i,
  input  logic [ADDR_W-1:0]               rd_addr_i,
  output logic [WIDTH_P-1:0]              rd_data_o,
  output logic [NUM_SYNAPSES*WIDTH_P-1:0] weights_o
);

  localparam logic [ADDR_W:0]   C_NUM  = (ADDR_W+1)'(NUM_SYNAPSES);
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(NUM_SYNAPSES - 1);
  localparam logic [15:0]       C_TAPS = 16'hB400;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_READY = 2'd2} state_e;

  state_e             state_q;
  logic [15:0]        lfsr_q;
  logic [15:0]        lfsr_d;
  logic [ADDR_W-1:0]  fill_addr_q;
  logic [WIDTH_P-1:0] rd_data_q;
  logic               fill_done_q;
  logic [WIDTH_P-1:0] weight_q [NUM_SYNAPSES];

  logic                      wr_fire, upd_fire;
  logic                      wr_in_range, upd_in_range, rd_in_range;
  logic [WIDTH_P-1:0]        upd_cur;
  logic signed [WIDTH_P+1:0] upd_sum;
  logic [WIDTH_P-1:0]        upd_clamped;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? C_TAPS : 16'h0000);

  assign busy_o      = (state_q == S_FILL);
  assign wr_ready_o  = !busy_o;
  assign upd_ready_o = !busy_o && !wr_valid_i;
  assign wr_fire     = wr_valid_i && wr_ready_o;
  assign upd_fire    = upd_valid_i && upd_ready_o;

  assign wr_in_range  = ({1'b0, wr_addr_i}  < C_NUM);
  assign upd_in_range = ({1'b0, upd_addr_i} < C_NUM);
  assign rd_in_range  = ({1'b0, rd_addr_i}  < C_NUM);

  // Two guard bits hold both the unsigned weight and the sign of the delta.
  assign upd_cur = upd_in_range ? weight_q[upd_addr_i] : '0;
  assign upd_sum = $signed({2'b00, upd_cur})
                 + $signed({{2{upd_delta_i[WIDTH_P-1]}}, upd_delta_i});

  always_comb begin
    upd_clamped = upd_sum[WIDTH_P-1:0];
    if (upd_sum[WIDTH_P+1]) begin
      upd_clamped = '0;
    end else if (upd_sum[WIDTH_P]) begin
      upd_clamped = '1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      fill_addr_q <= '0;
      rd_data_q   <= '0;
      fill_done_q <= 1'b0;
      for (int i = 0; i < NUM_SYNAPSES; i++) begin
        weight_q[i] <= '0;
      end
    end else begin
      fill_done_q <= 1'b0;
      rd_data_q   <= rd_in_range ? weight_q[rd_addr_i] : '0;

      case (state_q)
        S_FILL: begin
          lfsr_q                <= lfsr_d;
          weight_q[fill_addr_q] <= lfsr_d[WIDTH_P-1:0];
          fill_addr_q           <= fill_addr_q + ADDR_W'(1);
          if (fill_addr_q == C_LAST) begin
            state_q     <= S_READY;
            fill_done_q <= 1'b1;
            fill_addr_q <= '0;
          end
        end
        default: begin
          if (fill_start_i) begin
            lfsr_q      <= (seed_i == 16'h0000) ? LFSR_SEED : seed_i;
            fill_addr_q <= '0;
            state_q     <= S_FILL;
          end
        end
      endcase

      // Handshakes are exclusive and both are blocked during a fill.
      if (wr_fire && wr_in_range) begin
        weight_q[wr_addr_i] <= wr_data_i;
      end else if (upd_fire && upd_in_range) begin
        weight_q[upd_addr_i] <= upd_clamped;
      end
    end
  end

  assign rd_data_o   = rd_data_q;
  assign fill_done_o = fill_done_q;

  for (genvar gi = 0; gi < NUM_SYNAPSES; gi++) begin : g_flat
    assign weights_o[gi*WIDTH_P +: WIDTH_P] = weight_q[gi];
  end

endmodule

`default_nettype wire
